imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream loader that fills the 64×32-bit instruction memory before the processor runs. It accepts bytes over a valid/ready handshake, packs them little-endian into 32-bit words, and writes them to consecutive instruction-memory addresses starting at 0. It also drives the core stall and signals completion. It is the write-side counterpart of the instruction memory's read port and sits between the host/UART byte source and the memory's write port.

## Interface
- ADDR_W, 6, instruction-memory address width (64 words)
- DATA_W, 32, word width; only 32 is supported
- clk  in  1  single clock; everything is sampled on the rising edge
- rst  in  1  reset, synchronous and active-high
- start_i  in  1  starts a load; honoured only in IDLE
- n_words_i  in  ADDR_W+1  number of words to load, captured on start; values above 64 are clamped to 64
- byte_valid_i  in  1  a byte is offered on byte_i
- byte_i  in  8  data byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- mem_we_o  out  1  instruction-memory write enable
- mem_addr_o  out  ADDR_W  write address
- mem_wdata_o  out  32  write data
- busy_o  out  1  load in progress; also used as the core stall
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  checksum mismatch; see Configuration

## Operation
- FSM states: IDLE, RECV, WRITE, CSUM (macro only), DONE.
- **IDLE**
  - On start_i: capture clamp(n_words_i), clear the word counter, address and byte lane, and clear err_o.
  - Next state is DONE if the captured count is 0, otherwise RECV.
- **RECV**
  - byte_ready_o=1.
  - Each handshake (byte_valid_i & byte_ready_o) stores byte_i into lane byte_cnt: first byte to [7:0], fourth byte to [31:24].
  - After the 4th byte: byte_cnt returns to 0 and the state moves to WRITE.
  - Bytes are accepted only when valid and ready are both high.
- **WRITE**
  - mem_we_o=1 for exactly one cycle; mem_addr_o is the current address and mem_wdata_o is the packed word.
  - byte_ready_o=0.
  - Then the address and word counter increment. If count equals n_words, go to CSUM or DONE; otherwise go back to RECV.
- **DONE**
  - done_o=1 for one cycle, then return to IDLE.
- busy_o=1 in RECV, WRITE and CSUM; 0 in IDLE and DONE.
- start_i is ignored outside IDLE.
- The address never wraps, because the count is clamped to 64. The last write is at address 63.
- Outside WRITE: mem_we_o=0, and mem_addr_o/mem_wdata_o hold their last values.

## Timing
- Reset values:
  - state IDLE
  - byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0
- A reset mid-load discards the partial word and returns to IDLE on the next edge. Words already written stay in memory.
- Handshake latency:
  - The 4th byte accepted at edge t produces mem_we_o=1 during cycle t+1.
  - byte_ready_o rises again at t+2.
- Minimum time per word: 5 cycles (4 byte cycles plus 1 write cycle).
- start_i at edge t puts the loader in RECV, with byte_ready_o=1, in cycle t+1.
- byte_valid_i may be held high continuously, with a new byte each cycle. Bytes offered while byte_ready_o=0 are not consumed and must be held by the source.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- **Defined**
  - Maintain sum = Σ written words mod 2^32.
  - After the last WRITE, enter CSUM and receive 4 more bytes (little-endian) as the checksum word. These bytes are not written to memory.
  - In the DONE cycle, err_o is set if checksum ≠ sum and held until the next accepted start_i.
  - A zero-word load also expects a checksum: the sum is 0 and the state goes IDLE→CSUM.
- **Undefined**
  - No CSUM state and no adder.
  - err_o is tied to 0.

## Structure
- Package imem_loader_pkg holds:
  - the state enum
  - the ADDR_W default, 6
  - BYTES_PER_WORD=4
  - MAX_WORDS=64
- Sub-module imem_word_packer: byte lane counter plus 32-bit assembly register. It is reused for the checksum word.

## Test plan
- Single word: start_i with n_words=1, bytes E6,AC,01,67 → one write with addr 0, data 0x6701ACE6, then done_o one cycle later, busy_o low.
- Back-to-back words, valid held high: n_words=2, bytes E6,AC,01,67,59,23,52,59 → writes of 0x6701ACE6 at address 0 and 0x59522359 at address 1, 5 cycles apart; byte_ready_o=0 during each WRITE cycle.
- Gappy source: byte_valid_i toggling at random with n_words=3 → the same words land at addresses 0..2; no byte is duplicated or dropped.
- Clamp and boundary: n_words=100 with 64 words streamed → last write at address 63, then done_o; start_i pulsed mid-load is ignored.
- Reset mid-word after 2 bytes → all outputs return to reset values; a fresh load of 1 word writes the correct word at address 0.
- Checksum (macro defined): words 0x00000001 and 0x00000002 with checksum 0x00000003 give err_o=0; checksum 0x00000004 gives err_o=1, held until the next start_i.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
// Optional checksum stage is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int DEF_ADDR_W     = 6;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS      = 64;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

    // Replace one little-endian byte lane of a word.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [LANE_W-1:0] lane,
                                             input logic [7:0] data);
        logic [31:0] res;
        res = word;
        res[int'(lane)*8 +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Byte lane counter plus 32-bit little-endian word assembly register.
// word_next/last show the word as it stands including the byte accepted this cycle.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word_next,
    output logic        last
);

    logic [LANE_W-1:0] lane_r;
    logic [31:0]       word_r;

    // Merge the incoming byte into the word being assembled
    always_comb begin
        word_next = word_r;
        last      = 1'b0;
        if (accept) begin
            word_next = put_byte(word_r, lane_r, data);
            last      = (lane_r == LANE_W'(BYTES_PER_WORD - 1));
        end else begin
            word_next = word_r;
            last      = 1'b0;
        end
    end

    // Lane counter wraps naturally back to lane 0 after the top byte
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r <= {LANE_W{1'b0}};
            word_r <= 32'h0000_0000;
        end else if (clr) begin
            lane_r <= {LANE_W{1'b0}};
            word_r <= 32'h0000_0000;
        end else if (accept) begin
            lane_r <= lane_r + {{(LANE_W-1){1'b0}}, 1'b1};
            word_r <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction memory from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to append and verify a trailing checksum word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   n_words_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] MAX_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ZERO_C = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_TAIL = ST_CSUM;
`else
    localparam state_e ST_TAIL = ST_DONE;
`endif

    state_e              state_r;
    state_e              state_next_s;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     cnt_inc_s;
    logic [ADDR_W:0]     n_words_r;
    logic [ADDR_W:0]     n_clamp_s;
    logic                accept_s;
    logic                pack_clr_s;
    logic [31:0]         pack_word_s;
    logic                pack_last_s;
    logic                byte_ready_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                busy_r;
    logic                done_r;

    assign n_clamp_s = (n_words_i > MAX_C) ? MAX_C : n_words_i;
    assign cnt_inc_s = cnt_r + ONE_C;
    assign accept_s  = byte_valid_i & byte_ready_r;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pack_clr_s),
        .accept    (accept_s),
        .data      (byte_i),
        .word_next (pack_word_s),
        .last      (pack_last_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        pack_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    pack_clr_s = 1'b1;
                    if (n_clamp_s == ZERO_C) begin
                        state_next_s = ST_TAIL;
                    end else begin
                        state_next_s = ST_RECV;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (pack_last_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (cnt_inc_s == n_words_r) begin
                    state_next_s = ST_TAIL;
                end else begin
                    state_next_s = ST_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (pack_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
`endif
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= ZERO_C;
            n_words_r    <= ZERO_C;
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            byte_ready_r <= (state_next_s == ST_RECV) || (state_next_s == ST_TAIL && state_next_s != ST_DONE);
            busy_r       <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
            done_r       <= (state_next_s == ST_DONE);
            mem_we_r     <= (state_next_s == ST_WRITE);
            if (state_r == ST_IDLE && start_i) begin
                n_words_r <= n_clamp_s;
                cnt_r     <= ZERO_C;
            end
            if (state_next_s == ST_WRITE) begin
                mem_addr_r  <= cnt_r[ADDR_W-1:0];
                mem_wdata_r <= pack_word_s;
            end
            if (state_r == ST_WRITE) begin
                cnt_r <= cnt_inc_s;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_r;
    logic        err_r;

    // Running word sum and the trailing checksum comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 32'h0000_0000;
            err_r <= 1'b0;
        end else if (state_r == ST_IDLE && start_i) begin
            sum_r <= 32'h0000_0000;
            err_r <= 1'b0;
        end else if (state_r == ST_WRITE) begin
            sum_r <= sum_r + mem_wdata_r;
        end else if (state_r == ST_CSUM && pack_last_s) begin
            err_r <= (pack_word_s != sum_r);
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

    assign byte_ready_o = byte_ready_r;
    assign mem_we_o     = mem_we_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_wdata_o  = mem_wdata_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes/done pulses queued by stimulus, popped by a monitor.
// Follows IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [6:0]  n_words_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [5:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .n_words_i    (n_words_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic        done_q[$];
    logic [31:0] words[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_last = -1;
    int          we_prev = -1;
    int          done_cyc = -1;
    logic [5:0]  last_addr = 6'd0;
    wr_t         mon_e;
    logic        mon_err;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every write and every done pulse must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we_o) begin
                we_prev   = we_last;
                we_last   = cyc;
                last_addr = mem_addr_o;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr_o, mem_wdata_o);
                end else begin
                    mon_e = wr_q.pop_front();
                    check("wr_addr", 64'(mem_addr_o), 64'(mon_e.addr));
                    check("wr_data", 64'(mem_wdata_o), 64'(mon_e.data));
                end
                check("ready_in_write", 64'(byte_ready_o), 64'd0);
                check("busy_in_write", 64'(busy_o), 64'd1);
            end
            if (done_o) begin
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 expected 0");
                end else begin
                    mon_err = done_q.pop_front();
                    check("err_at_done", 64'(err_o), 64'(mon_err));
                end
                check("busy_at_done", 64'(busy_o), 64'd0);
            end
        end
    end

    // Offer one byte, optionally after random idle cycles; returns once it is consumed
    task automatic send_byte(input logic [7:0] b, input bit gappy, input bit pulse_start);
        bit ok;
        int g;
        if (gappy) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        start_i      = pulse_start;
        n_words_i    = 7'($urandom);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = byte_ready_o;
            @(negedge clk);
            start_i = 1'b0;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got no byte_ready_o expected ready within 50 cycles");
        end
        byte_valid_i = 1'b0;
    endtask

    // Reference model: words[] land at addresses 0.. up to the clamped count
    task automatic run_load(input int n_req, input bit gappy, input bit bad_csum, input int mid_start_word);
        int          n_eff;
        logic [31:0] sum;
        logic [31:0] csum;
        bit          exp_err;
        n_eff   = (n_req > 64) ? 64 : n_req;
        sum     = 32'h0;
        exp_err = CSUM_ON & bad_csum;
        for (int i = 0; i < n_eff; i++) begin
            wr_q.push_back('{6'(i), words[i]});
            sum = sum + words[i];
        end
        done_q.push_back(exp_err);
        start_i   = 1'b1;
        n_words_i = 7'(n_req);
        @(negedge clk);
        start_i   = 1'b0;
        check("ready_after_start", 64'(byte_ready_o), 64'(n_eff > 0 || CSUM_ON));
        check("busy_after_start", 64'(busy_o), 64'(n_eff > 0 || CSUM_ON));
        check("err_cleared_on_start", 64'(err_o), 64'd0);
        for (int i = 0; i < n_eff; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(words[i] >> (8 * k)), gappy, (i == mid_start_word) && (k == 0));
            end
        end
        if (CSUM_ON) begin
            csum = sum + (bad_csum ? 32'd1 : 32'd0);
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(csum >> (8 * k)), gappy, 1'b0);
            end
        end
        for (int k = 0; k < 50 && done_q.size() > 0; k++) @(posedge clk);
        if (done_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o expected pulse within 50 cycles");
            done_q.delete();
        end
        check("writes_outstanding", 64'(wr_q.size()), 64'd0);
        wr_q.delete();
        @(negedge clk);
        if (!CSUM_ON && n_eff > 0) check("done_latency", 64'(done_cyc - we_last), 64'd1);
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy_o), 64'd0);
        check("err_held", 64'(err_o), 64'(exp_err));
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        n_words_i    = 7'd0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, err_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word
        words = '{32'h6701ACE6};
        run_load(1, 1'b0, 1'b0, -1);

        // Two words, valid held high: writes five cycles apart
        words = '{32'h6701ACE6, 32'h59522359};
        run_load(2, 1'b0, 1'b0, -1);
        check("write_spacing", 64'(we_last - we_prev), 64'd5);

        // Gappy source
        random_words(3);
        run_load(3, 1'b1, 1'b0, -1);

        // Clamp to 64 words, with a start pulse mid-load
        random_words(64);
        run_load(100, 1'b0, 1'b0, 10);
        check("last_addr", 64'(last_addr), 64'd63);

        // Reset after two bytes of a word
        start_i   = 1'b1;
        n_words_i = 7'd1;
        @(negedge clk);
        start_i   = 1'b0;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_load", {byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, err_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        random_words(1);
        run_load(1, 1'b0, 1'b0, -1);

        // Zero-word load
        words.delete();
        run_load(0, 1'b0, 1'b0, -1);

        // Checksum good then bad, bad one held until the next start
        words = '{32'h00000001, 32'h00000002};
        run_load(2, 1'b0, 1'b0, -1);
        run_load(2, 1'b0, 1'b1, -1);

        // Random loads
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 5);
            random_words(n);
            run_load(n, 1'($urandom), 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
